// File: rtl/ex_div_pkg.sv
// Shared constants and state encoding for the iterative execute-stage divider.
package ex_div_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  // Execute-stage ALU op codes that route to this unit.
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/ex_div.sv
// Radix-2 restoring divider for DIV/DIVU; result packs {remainder, quotient} for HI/LO.
// CNT_W must satisfy 2**CNT_W > WIDTH so the counter can reach WIDTH.
module ex_div
  import ex_div_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   op1_mag, op2_mag;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic               op1_neg, op2_neg;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_d   = ready_q;

    op1_neg = signed_div_i & opdata1_i[WIDTH-1];
    op2_neg = signed_div_i & opdata2_i[WIDTH-1];
    op1_mag = op1_neg ? -opdata1_i : opdata1_i;
    op2_mag = op2_neg ? -opdata2_i : opdata2_i;

    // Partial remainder is WIDTH+1 bits; its MSB after subtracting is the borrow.
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, divisor_q};
    quo_fix = neg_quo_q ? -quo_q : quo_q;
    rem_fix = neg_rem_q ? -rem_q : rem_q;

    unique case (state_q)
      DivFree: begin
        if (start_i == DivStart && !annul_i) begin
          rem_d     = '0;
          quo_d     = op1_mag;
          divisor_d = op2_mag;
          neg_quo_d = op1_neg ^ op2_neg;
          neg_rem_d = op1_neg;
          cnt_d     = '0;
          state_d   = (opdata2_i == '0) ? DivByZero : DivOn;
        end
      end
      DivByZero: begin
        result_d = '0;
        ready_d  = DivResultReady;
        state_d  = DivEnd;
      end
      DivOn: begin
        if (annul_i) begin
          cnt_d   = '0;
          state_d = DivFree;
        end else if (cnt_q == CNT_W'(WIDTH)) begin
          result_d = {rem_fix, quo_fix};
          ready_d  = DivResultReady;
          state_d  = DivEnd;
        end else begin
          if (!diff[WIDTH]) begin
            rem_d = diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DivEnd: begin
        if (start_i == DivStop) begin
          result_d = '0;
          ready_d  = DivResultNotReady;
          state_d  = DivFree;
        end
      end
      default: state_d = DivFree;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= DivFree;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= DivResultNotReady;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      divisor_q <= divisor_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = (state_q == DivByZero) || (state_q == DivOn);

endmodule

// File: tb/tb_ex_div.sv
// Directed table-driven bench for ex_div plus hand-written multi-cycle corner sequences.
module tb_ex_div;

  localparam int unsigned W = 32;

  logic          clk;
  logic          rst;
  logic          signed_div_i;
  logic [W-1:0]  opdata1_i;
  logic [W-1:0]  opdata2_i;
  logic          start_i;
  logic          annul_i;
  logic [2*W-1:0] result_o;
  logic          ready_o;
  logic          busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  ex_div #(.WIDTH(W), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one operation from an idle negedge and check the full handshake.
  task automatic run_op(input string name, input logic sgn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] hi, input logic [W-1:0] lo);
    int   lat;
    logic early;
    lat          = (b == '0) ? 1 : W + 1;
    early        = 1'b0;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({name, " busy"}, 64'(busy_o), 64'd1);
    early |= ready_o;
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k < lat) early |= ready_o;
    end
    chk({name, " early_ready"}, 64'(early), 64'd0);
    chk({name, " ready"}, 64'(ready_o), 64'd1);
    chk({name, " result"}, result_o, {hi, lo});
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({name, " drop_ready"}, 64'(ready_o), 64'd0);
    chk({name, " drop_result"}, result_o, 64'd0);
  endtask

  vec_t vecs[$];

  initial begin
    logic          early;
    logic [2*W-1:0] held;

    vecs.push_back('{1'b0, 32'd100,        32'd7,        32'd2,        32'd14});
    vecs.push_back('{1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back('{1'b1, 32'd7,          32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD});
    vecs.push_back('{1'b0, 32'd5,          32'd0,        32'd0,        32'd0});
    vecs.push_back('{1'b1, 32'd5,          32'd0,        32'd0,        32'd0});
    vecs.push_back('{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'd0,        32'h80000000});
    vecs.push_back('{1'b0, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'd0});
    vecs.push_back('{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14});
    vecs.push_back('{1'b0, 32'hFFFFFFF9,   32'd2,        32'd1,        32'h7FFFFFFC});
    vecs.push_back('{1'b0, 32'd3,          32'd10,       32'd3,        32'd0});

    rst          = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    #12;
    chk("reset outputs", {result_o[W-1:0], 30'd0, ready_o, busy_o}, 64'd0);
    chk("reset result_hi", 64'(result_o[2*W-1:W]), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
      @(negedge clk);
    end

    // Annul at E10: back to idle, no result, then a fresh request still works.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    @(posedge clk);
    for (int k = 1; k < 10; k++) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    annul_i = 1'b0;
    early   = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      early |= ready_o | busy_o;
    end
    chk("annul idle", 64'(early), 64'd0);
    run_op("after_annul", 1'b0, 32'd9, 32'd3, 32'd0, 32'd3);
    @(negedge clk);

    // Dropping start mid-operation does not cancel it.
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    for (int k = 1; k <= W + 1; k++) @(posedge clk);
    @(negedge clk);
    chk("nocancel ready", 64'(ready_o), 64'd1);
    chk("nocancel result", result_o, {32'd2, 32'd14});
    @(negedge clk);
    chk("nocancel release", 64'(ready_o), 64'd0);

    // Asynchronous reset: mid-DivOn, then while a nonzero result is held.
    opdata1_i = 32'd123456;
    opdata2_i = 32'd7;
    start_i   = 1'b1;
    for (int k = 0; k < 5; k++) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst mid busy", 64'(busy_o), 64'd0);
    chk("rst mid ready", 64'(ready_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    for (int k = 0; k < W + 2; k++) @(posedge clk);
    @(negedge clk);
    chk("pre_rst ready", 64'(ready_o), 64'd1);
    chk("pre_rst result", result_o, {32'd4, 32'd17636});
    #2;
    rst = 1'b0;
    #1;
    chk("rst async result", result_o, 64'd0);
    chk("rst async ready", 64'(ready_o), 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_op("after_rst", 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF);
    @(negedge clk);

    // Operand isolation: scramble inputs after accept, hold start past ready.
    signed_div_i = 1'b1;
    opdata1_i    = 32'hFFFFFFF9;
    opdata2_i    = 32'd2;
    start_i      = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= W + 1; k++) begin
      @(negedge clk);
      opdata1_i    = $urandom;
      opdata2_i    = $urandom;
      signed_div_i = 1'($urandom_range(1));
      @(posedge clk);
    end
    @(negedge clk);
    chk("iso ready", 64'(ready_o), 64'd1);
    chk("iso result", result_o, {32'hFFFFFFFF, 32'hFFFFFFFD});
    held  = {32'hFFFFFFFF, 32'hFFFFFFFD};
    early = 1'b0;
    for (int k = 0; k < 5; k++) begin
      opdata1_i = $urandom;
      opdata2_i = $urandom;
      annul_i   = 1'($urandom_range(1));
      @(posedge clk);
      @(negedge clk);
      if (!ready_o || result_o !== held) early = 1'b1;
    end
    annul_i = 1'b0;
    chk("iso stable", 64'(early), 64'd0);
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("iso release", {32'd0, result_o[W-1:0]} | 64'(ready_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
